// File: rtl/scr_pkg.sv
// Shared types and op-code decode helpers for the scratch-RAM stack sequencer.
package scr_pkg;

  localparam int SCR_DATA_W = 10;
  localparam int SCR_ADDR_W = 8;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_ST      = 3'd1,
    OP_LD      = 3'd2,
    OP_PUSH    = 3'd3,
    OP_POP     = 3'd4,
    OP_CALL    = 3'd5,
    OP_RET     = 3'd6,
    OP_SP_LOAD = 3'd7
  } scr_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } scr_state_t;

  function automatic logic op_writes(input scr_op_t op);
    logic w;
    case (op)
      OP_ST, OP_PUSH, OP_CALL: w = 1'b1;
      default:                 w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic op_reads(input scr_op_t op);
    logic r;
    case (op)
      OP_LD, OP_POP, OP_RET: r = 1'b1;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_pushes(input scr_op_t op);
    logic p;
    case (op)
      OP_PUSH, OP_CALL: p = 1'b1;
      default:          p = 1'b0;
    endcase
    return p;
  endfunction

  function automatic logic op_pops(input scr_op_t op);
    logic p;
    case (op)
      OP_POP, OP_RET: p = 1'b1;
      default:        p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/scr_sp_reg.sv
// Stack pointer register: decrement/increment/load with 8-bit wrap detection.
module scr_sp_reg #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SP_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_next,
  output logic              ovf_evt,
  output logic              unf_evt,
  output logic              ovf,
  output logic              unf
);

  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SP_EMPTY = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] SP_FULL  = {ADDR_W{1'b1}};

  logic [ADDR_W-1:0] sp_r;
  logic [ADDR_W-1:0] sp_next_s;
  logic              ovf_s;
  logic              unf_s;
  logic              ovf_r;
  logic              unf_r;

  // Next SP and wrap events; load has priority over +/-1.
  always_comb begin
    sp_next_s = sp_r;
    ovf_s     = 1'b0;
    unf_s     = 1'b0;
    if (load) begin
      sp_next_s = load_val;
    end else if (dec) begin
      sp_next_s = sp_r - ONE;
      ovf_s     = (sp_r == SP_EMPTY);
    end else if (inc) begin
      sp_next_s = sp_r + ONE;
      unf_s     = (sp_r == SP_FULL);
    end else begin
      sp_next_s = sp_r;
    end
  end

  // SP register and one-cycle wrap pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r  <= SP_RESET;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      sp_r  <= sp_next_s;
      ovf_r <= ovf_s;
      unf_r <= unf_s;
    end
  end

  assign sp      = sp_r;
  assign sp_next = sp_next_s;
  assign ovf_evt = ovf_s;
  assign unf_evt = unf_s;
  assign ovf     = ovf_r;
  assign unf     = unf_r;

endmodule

// File: rtl/scr_stack_ctrl.sv
// Scratch-RAM sequencer: two-cycle IDLE/EXEC handshake turning ST/LD/PUSH/POP/CALL/RET/SP_LOAD
// requests into registered RAM address, data and write enable.
module scr_stack_ctrl
  import scr_pkg::*;
#(
  parameter int                DATA_W   = SCR_DATA_W,
  parameter int                ADDR_W   = SCR_ADDR_W,
  parameter logic [ADDR_W-1:0] SP_RESET = 8'h00
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [2:0]        REQ_OP,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic [DATA_W-1:0] SCR_DATA,
  output logic              SCR_WE,
  input  logic [DATA_W-1:0] SCR_DATA_OUT,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic [ADDR_W-1:0] SP,
  output logic              STACK_OVF,
  output logic              STACK_UNF,
  output logic              STACK_ERR
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  scr_state_t        state_r;
  scr_state_t        state_nxt_s;
  logic              accept_s;
  logic              finish_s;
  scr_op_t           req_op_s;
  scr_op_t           op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] exec_addr_s;
  logic [ADDR_W-1:0] scr_addr_r;
  logic [DATA_W-1:0] scr_data_r;
  logic              scr_we_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              stack_err_r;
  logic [ADDR_W-1:0] sp_s;
  logic [ADDR_W-1:0] sp_next_s;
  logic              ovf_evt_s;
  logic              unf_evt_s;

  assign req_op_s = scr_op_t'(REQ_OP);

  scr_sp_reg #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_sp (
    .clk      (CLK),
    .rst_n    (RST_N),
    .dec      (finish_s && op_pushes(op_r)),
    .inc      (finish_s && op_pops(op_r)),
    .load     (finish_s && (op_r == OP_SP_LOAD)),
    .load_val (addr_r),
    .sp       (sp_s),
    .sp_next  (sp_next_s),
    .ovf_evt  (ovf_evt_s),
    .unf_evt  (unf_evt_s),
    .ovf      (STACK_OVF),
    .unf      (STACK_UNF)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus accept/finish strobes; every request spends exactly one cycle in EXEC.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (REQ_VALID) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        finish_s    = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // RAM address for the upcoming EXEC cycle, decided from the request at accept time.
  always_comb begin
    exec_addr_s = sp_s;
    case (req_op_s)
      OP_ST, OP_LD:     exec_addr_s = REQ_ADDR;
      OP_PUSH, OP_CALL: exec_addr_s = sp_s - ONE;
      default:          exec_addr_s = sp_s;
    endcase
  end

  // Registered RAM interface, read capture and sticky error flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_r        <= OP_NOP;
      addr_r      <= {ADDR_W{1'b0}};
      scr_addr_r  <= SP_RESET;
      scr_data_r  <= {DATA_W{1'b0}};
      scr_we_r    <= 1'b0;
      rd_data_r   <= {DATA_W{1'b0}};
      rd_valid_r  <= 1'b0;
      stack_err_r <= 1'b0;
    end else if (accept_s) begin
      op_r       <= req_op_s;
      addr_r     <= REQ_ADDR;
      scr_addr_r <= exec_addr_s;
      scr_data_r <= REQ_DATA;
      scr_we_r   <= op_writes(req_op_s);
      rd_valid_r <= 1'b0;
    end else if (finish_s) begin
      scr_we_r   <= 1'b0;
      scr_addr_r <= sp_next_s;
      rd_valid_r <= op_reads(op_r);
      if (op_reads(op_r)) begin
        rd_data_r <= SCR_DATA_OUT;
      end
      if (op_r == OP_SP_LOAD) begin
        stack_err_r <= 1'b0;
      end else if (ovf_evt_s || unf_evt_s) begin
        stack_err_r <= 1'b1;
      end
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign REQ_READY = (state_r == ST_IDLE);
  assign SCR_ADDR  = scr_addr_r;
  assign SCR_DATA  = scr_data_r;
  assign SCR_WE    = scr_we_r;
  assign RD_DATA   = rd_data_r;
  assign RD_VALID  = rd_valid_r;
  assign SP        = sp_s;
  assign STACK_ERR = stack_err_r;

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Self-checking bench for scr_stack_ctrl: directed vector table, hand-written reset/backpressure
// sequences, then random ops checked against a behavioural stack/RAM model.
module tb_scr_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_addr;
  logic [9:0] req_data;
  logic [7:0] scr_addr;
  logic [9:0] scr_data;
  logic       scr_we;
  logic [9:0] scr_data_out;
  logic [9:0] rd_data;
  logic       rd_valid;
  logic [7:0] sp;
  logic       stack_ovf;
  logic       stack_unf;
  logic       stack_err;

  always #5 clk = ~clk;

  scr_stack_ctrl dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .REQ_VALID    (req_valid),
    .REQ_READY    (req_ready),
    .REQ_OP       (req_op),
    .REQ_ADDR     (req_addr),
    .REQ_DATA     (req_data),
    .SCR_ADDR     (scr_addr),
    .SCR_DATA     (scr_data),
    .SCR_WE       (scr_we),
    .SCR_DATA_OUT (scr_data_out),
    .RD_DATA      (rd_data),
    .RD_VALID     (rd_valid),
    .SP           (sp),
    .STACK_OVF    (stack_ovf),
    .STACK_UNF    (stack_unf),
    .STACK_ERR    (stack_err)
  );

  // Scratch RAM: synchronous write, asynchronous read, preloaded with a known pattern.
  logic [9:0] ram [256];
  logic       ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 10'(i * 7 + 3);
    end else if (scr_we) begin
      ram[scr_addr] <= scr_data;
    end
  end
  assign scr_data_out = ram[scr_addr];

  // Reference model state
  int m_mem [256];
  int m_sp;
  int m_rd;
  bit m_err;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [9:0] d, input bit hold);
    int n;
    int e_addr;
    bit e_we, e_rv, e_ovf, e_unf, ramop;
    e_we = 0; e_rv = 0; e_ovf = 0; e_unf = 0; ramop = 1; e_addr = m_sp;
    case (op)
      3'd1: begin e_we = 1; e_addr = a; m_mem[a] = d; end
      3'd2: begin e_rv = 1; e_addr = a; m_rd = m_mem[a]; end
      3'd3, 3'd5: begin
        e_ovf = (m_sp == 0);
        m_sp = (m_sp + 255) % 256;
        e_addr = m_sp; e_we = 1; m_mem[m_sp] = d;
      end
      3'd4, 3'd6: begin
        e_unf = (m_sp == 255);
        e_addr = m_sp; e_rv = 1; m_rd = m_mem[m_sp];
        m_sp = (m_sp + 1) % 256;
      end
      3'd7: begin m_sp = a; m_err = 0; ramop = 0; end
      default: ramop = 0;
    endcase
    if (e_ovf || e_unf) m_err = 1;

    req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    check("exec_ready", req_ready, 1'b0);
    check("exec_we", scr_we, e_we);
    if (ramop) check("exec_addr", scr_addr, e_addr);
    if (e_we) check("exec_wdata", scr_data, d);
    if (!hold) req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("post_ready", req_ready, 1'b1);
    check("post_we", scr_we, 1'b0);
    check("rd_valid", rd_valid, e_rv);
    check("rd_data", rd_data, m_rd);
    check("sp", sp, m_sp);
    check("idle_addr", scr_addr, m_sp);
    check("ovf", stack_ovf, e_ovf);
    check("unf", stack_unf, e_unf);
    check("err", stack_err, m_err);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] addr;
    logic [9:0] data;
    logic [7:0] e_sp;
    logic       e_rv;
    logic [9:0] e_rd;
    logic       e_ovf;
    logic       e_unf;
    logic       e_err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    logic [7:0] a;
    int         sel;

    tbl[0]  = '{3'd1, 8'h03, 10'h0FF, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0}; // ST
    tbl[1]  = '{3'd2, 8'h03, 10'h000, 8'h00, 1'b1, 10'h0FF, 1'b0, 1'b0, 1'b0}; // LD
    tbl[2]  = '{3'd7, 8'h80, 10'h000, 8'h80, 1'b0, 10'h0FF, 1'b0, 1'b0, 1'b0}; // SP_LOAD
    tbl[3]  = '{3'd3, 8'h00, 10'h155, 8'h7F, 1'b0, 10'h0FF, 1'b0, 1'b0, 1'b0}; // PUSH
    tbl[4]  = '{3'd4, 8'h00, 10'h000, 8'h80, 1'b1, 10'h155, 1'b0, 1'b0, 1'b0}; // POP
    tbl[5]  = '{3'd5, 8'h00, 10'h2A0, 8'h7F, 1'b0, 10'h155, 1'b0, 1'b0, 1'b0}; // CALL
    tbl[6]  = '{3'd5, 8'h00, 10'h3FF, 8'h7E, 1'b0, 10'h155, 1'b0, 1'b0, 1'b0}; // CALL
    tbl[7]  = '{3'd6, 8'h00, 10'h000, 8'h7F, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0}; // RET
    tbl[8]  = '{3'd6, 8'h00, 10'h000, 8'h80, 1'b1, 10'h2A0, 1'b0, 1'b0, 1'b0}; // RET
    tbl[9]  = '{3'd7, 8'h00, 10'h000, 8'h00, 1'b0, 10'h2A0, 1'b0, 1'b0, 1'b0}; // SP_LOAD
    tbl[10] = '{3'd3, 8'h00, 10'h001, 8'hFF, 1'b0, 10'h2A0, 1'b1, 1'b0, 1'b1}; // PUSH wraps
    tbl[11] = '{3'd4, 8'h00, 10'h000, 8'h00, 1'b1, 10'h001, 1'b0, 1'b1, 1'b1}; // POP wraps
    tbl[12] = '{3'd7, 8'h40, 10'h000, 8'h40, 1'b0, 10'h001, 1'b0, 1'b0, 1'b0}; // SP_LOAD clears
    tbl[13] = '{3'd0, 8'h00, 10'h000, 8'h40, 1'b0, 10'h001, 1'b0, 1'b0, 1'b0}; // NOP

    for (int i = 0; i < 256; i++) m_mem[i] = (i * 7 + 3) % 1024;
    m_sp = 0; m_rd = 0; m_err = 0;

    rst_n = 1'b0; ram_init = 1'b1;
    req_valid = 1'b0; req_op = 3'd0; req_addr = 8'h00; req_data = 10'h000;
    @(negedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sp", sp, 8'h00);
    check("rst_we", scr_we, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_err", stack_err, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 10'h000);
    check("rst_scr_addr", scr_addr, 8'h00);
    check("rst_scr_data", scr_data, 10'h000);

    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i].op, tbl[i].addr, tbl[i].data, 1'b0);
      check("tbl_sp", sp, tbl[i].e_sp);
      check("tbl_rd_valid", rd_valid, tbl[i].e_rv);
      check("tbl_rd_data", rd_data, tbl[i].e_rd);
      check("tbl_ovf", stack_ovf, tbl[i].e_ovf);
      check("tbl_unf", stack_unf, tbl[i].e_unf);
      check("tbl_err", stack_err, tbl[i].e_err);
    end

    // REQ_VALID held across the busy cycle must be accepted exactly once.
    do_op(3'd3, 8'h00, 10'h2B5, 1'b1);
    @(negedge clk);
    check("hold_sp_once", sp, 8'h3F);
    check("hold_ready", req_ready, 1'b1);
    check("hold_we", scr_we, 1'b0);

    // Reset asserted during EXEC of a PUSH (target 3E): write must not land.
    req_op = 3'd3; req_addr = 8'h00; req_data = 10'h3AA; req_valid = 1'b1;
    @(negedge clk);
    check("mid_exec_we", scr_we, 1'b1);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("mid_rst_we_drop", scr_we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_sp = 0; m_err = 0; m_rd = 0;
    check("mid_rst_sp", sp, 8'h00);
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_rd_data", rd_data, 10'h000);
    do_op(3'd2, 8'h3E, 10'h000, 1'b0);
    check("mid_rst_no_write", rd_data, 10'(8'h3E * 7 + 3));

    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      if (op == 3'd7) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0: a = 8'h00;
          1: a = 8'hFF;
          2: a = 8'h01;
          3: a = 8'hFE;
          default: a = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_op(op, a, 10'($urandom_range(0, 1023)), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
